// File: rtl/capi_mmio_trigger_sched.sv
// MMIO trigger scheduler: decodes doorbell writes into pending bits and
// issues them one at a time, round-robin, to a shared engine.
module capi_mmio_trigger_sched #(
    parameter int unsigned        addr_width = 25,
    parameter int unsigned        id_width   = 2,
    parameter logic [0:addr_width-2] base_addr = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [0:addr_width-1]     wa,
    input  logic                      we,
    output logic                      req_v,
    output logic [id_width-1:0]       req_id,
    input  logic                      req_r,
    input  logic                      done,
    output logic                      busy,
    output logic [(2**id_width)-1:0]  pending,
    output logic [(2**id_width)-1:0]  ovf
);

    localparam int unsigned num_trig = 2**id_width;
    // Last bit of the doubleword address that must match base_addr
    localparam int unsigned tag_lsb  = addr_width - 2 - id_width;

    typedef logic [num_trig-1:0] vec_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    logic [id_width-1:0] last;
    logic [id_width-1:0] win_id;
    logic [id_width-1:0] wr_idx;
    logic                win_found;
    logic                hit;
    logic                grant;
    vec_t                wr_vec;
    vec_t                set_vec;
    vec_t                oclr_vec;
    vec_t                clr_vec;

    // Decode an MMIO write into a trigger set or an overflow clear
    always_comb begin
        hit      = we && (wa[0:tag_lsb] == base_addr[0:tag_lsb]);
        wr_idx   = wa[tag_lsb+1 : addr_width-2];
        wr_vec   = vec_t'(1) << wr_idx;
        set_vec  = (hit && !wa[addr_width-1]) ? wr_vec : '0;
        oclr_vec = (hit &&  wa[addr_width-1]) ? wr_vec : '0;
    end

    // Round-robin search starting one past the last granted index
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 1; k <= num_trig; k++) begin
            if (!win_found && pending[last + id_width'(k)]) begin
                win_found = 1'b1;
                win_id    = last + id_width'(k);
            end
        end
    end

    // Grant happens only from IDLE; it clears the winner's pending bit
    always_comb begin
        grant   = (state == IDLE) && win_found;
        clr_vec = grant ? (vec_t'(1) << win_id) : '0;
    end

    // Pending doorbells and sticky overflow; a set wins over a same-cycle grant clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
            ovf     <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            ovf     <= (ovf | (set_vec & pending & ~clr_vec)) & ~oclr_vec;
        end
    end

    // Issue state machine with registered request/busy outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            req_v  <= 1'b0;
            req_id <= '0;
            busy   <= 1'b0;
            last   <= id_width'(num_trig - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state  <= ISSUE;
                        req_v  <= 1'b1;
                        busy   <= 1'b1;
                        req_id <= win_id;
                        last   <= win_id;
                    end
                end
                ISSUE: begin
                    // done is meaningless before acceptance
                    if (req_r) begin
                        state <= WAIT;
                        req_v <= 1'b0;
                    end
                end
                WAIT: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_v <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
